// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered flags, occupancy and error pulses.
// Latency: a pushed word reaches rdata right after its write edge when the FIFO was empty.
// Backpressure: pushes are dropped while wfull, pops ignored while rempty; each raises a one-cycle pulse.
module sync_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic [ASIZE:0]   wcount,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic [ASIZE:0] wptr_next;
  logic [ASIZE:0] rptr_next;
  logic [ASIZE:0] wcount_next;
  logic           push_ok;
  logic           pop_ok;
  logic           wfull_next;
  logic           rempty_next;

  // Accept decisions use the current registered flags only, so a same-cycle
  // pop never frees a slot for a push and a same-cycle push never feeds a pop.
  always_comb begin
    push_ok     = winc & ~wfull;
    pop_ok      = rinc & ~rempty;
    wptr_next   = push_ok ? wptr + 1'b1 : wptr;
    rptr_next   = pop_ok  ? rptr + 1'b1 : rptr;
    wcount_next = wptr_next - rptr_next;
    rempty_next = (wptr_next == rptr_next);
    wfull_next  = (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]) &&
                  (wptr_next[ASIZE] != rptr_next[ASIZE]);
  end

  // Pointer, flag, count and error-pulse registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      wcount    <= '0;
      rempty    <= 1'b1;
      wfull     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      wcount    <= wcount_next;
      rempty    <= rempty_next;
      wfull     <= wfull_next;
      overflow  <= winc & wfull;
      underflow <= rinc & rempty;
    end
  end

  // Storage is not reset; it is written only by an accepted push outside reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  // Head of queue is presented combinationally; zero when nothing is stored.
  always_comb begin
    rdata = '0;
    if (!rempty) begin
      rdata = mem[rptr[ASIZE-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
    logic [4:0] wcount;
    logic       overflow;
    logic       underflow;

    sync_fifo #(.DSIZE(8), .ASIZE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wdata     (wdata),
        .winc      (winc),
        .rinc      (rinc),
        .rdata     (rdata),
        .wfull     (wfull),
        .rempty    (rempty),
        .wcount    (wcount),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock edge: inputs driven before the edge, outputs expected after it.
    typedef struct {
        string      name;
        logic       rst_n;
        logic       winc;
        logic       rinc;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       wfull;
        logic       rempty;
        logic [4:0] wcount;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec   = 0;
    int   n_fail  = 0;
    bit   tb_done = 1'b0;

    function automatic void add(string n, logic r, logic wi, logic ri, logic [7:0] wd,
                                logic [7:0] rd, logic f, logic e, int c, logic o, logic u);
        vec_t v;
        v.name   = n;
        v.rst_n  = r;
        v.winc   = wi;
        v.rinc   = ri;
        v.wdata  = wd;
        v.rdata  = rd;
        v.wfull  = f;
        v.rempty = e;
        v.wcount = 5'(c);
        v.ovf    = o;
        v.unf    = u;
        vecs.push_back(v);
    endfunction

    logic [7:0] fill_words [16];

    initial begin
        #20000;
        if (!tb_done) begin
            n_fail++;
            $display("FAIL timeout: bench did not finish within the allotted wait");
            $finish;
        end
    end

    initial begin
        fill_words = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h21, 8'h22, 8'h23, 8'h24,
                       8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h30, 8'h31, 8'h32};

        // Reset: first edge with X requests, second with both requests high.
        add("reset_x",   1'b0, 1'bx, 1'bx, 8'hxx, 8'h00, 0, 1, 0, 0, 0);
        add("reset_req", 1'b0, 1'b1, 1'b1, 8'hAA, 8'h00, 0, 1, 0, 0, 0);

        // Fill to full; head stays at the first word.
        for (int i = 0; i < 16; i++)
            add($sformatf("fill%0d", i), 1, 1, 0, fill_words[i], 8'h12, (i == 15), 0, i + 1, 0, 0);
        add("push_full", 1, 1, 0, 8'h33, 8'h12, 1, 0, 16, 1, 0);
        add("idle_full", 1, 0, 0, 8'h00, 8'h12, 1, 0, 16, 0, 0);

        // Drain in order; 0x33 must not appear.
        for (int k = 1; k <= 16; k++)
            add($sformatf("drain%0d", k), 1, 0, 1, 8'h00, (k < 16) ? fill_words[k] : 8'h00,
                0, (k == 16), 16 - k, 0, 0);
        add("pop_empty",  1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        add("idle_empty", 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);

        // Streaming from fresh reset: first edge is push-only and the blocked pop pulses underflow.
        add("reset2",   0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
        add("stream0",  1, 1, 1, 8'h12, 8'h12, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 40; i++)
            add($sformatf("stream%0d", i), 1, 1, 1, 8'(8'h12 + i), 8'(8'h12 + i), 0, 0, 1, 0, 0);
        add("stream_end", 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0);

        // Full with simultaneous requests: pop only, push blocked and flagged.
        for (int i = 0; i < 16; i++)
            add($sformatf("refill%0d", i), 1, 1, 0, 8'(8'h40 + i), 8'h40, (i == 15), 0, i + 1, 0, 0);
        add("full_both",  1, 1, 1, 8'h99, 8'h41, 0, 0, 15, 1, 0);
        add("refull",     1, 1, 0, 8'h55, 8'h41, 1, 0, 16, 0, 0);
        add("pop_after",  1, 0, 1, 8'h00, 8'h42, 0, 0, 15, 0, 0);

        // Mid-operation reset discards contents; next accesses behave as fresh.
        add("reset3", 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add($sformatf("five%0d", i), 1, 1, 0, 8'(8'h60 + i), 8'h60, 0, 0, i + 1, 0, 0);
        add("mid_reset",  0, 1, 1, 8'hEE, 8'h00, 0, 1, 0, 0, 0);
        add("post_pop",   1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        add("post_push",  1, 1, 0, 8'h77, 8'h77, 0, 0, 1, 0, 0);
        add("post_drain", 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0);

        rst_n = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            winc  = vecs[i].winc;
            rinc  = vecs[i].rinc;
            wdata = vecs[i].wdata;
            @(posedge clk);
            #1;
            n_vec++;
            if (rdata !== vecs[i].rdata || wfull !== vecs[i].wfull || rempty !== vecs[i].rempty ||
                wcount !== vecs[i].wcount || overflow !== vecs[i].ovf || underflow !== vecs[i].unf) begin
                n_fail++;
                $display("FAIL %s: got rdata=%02h full=%b empty=%b cnt=%0d ovf=%b unf=%b, want rdata=%02h full=%b empty=%b cnt=%0d ovf=%b unf=%b",
                         vecs[i].name, rdata, wfull, rempty, wcount, overflow, underflow,
                         vecs[i].rdata, vecs[i].wfull, vecs[i].rempty, vecs[i].wcount,
                         vecs[i].ovf, vecs[i].unf);
            end
        end

        // Final reset-state check: push a word, then reset with both requests high.
        @(negedge clk);
        rst_n = 1'b1;
        winc  = 1'b1;
        rinc  = 1'b0;
        wdata = 8'h5A;
        @(negedge clk);
        rst_n = 1'b0;
        winc  = 1'b1;
        rinc  = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (rdata !== 8'h00 || wfull !== 1'b0 || rempty !== 1'b1 || wcount !== 5'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL final_reset: got rdata=%02h full=%b empty=%b cnt=%0d ovf=%b unf=%b",
                     rdata, wfull, rempty, wcount, overflow, underflow);
        end

        tb_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
